inst_fetch: RTL

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch_pkg.sv | 14 +
 rtl/inst_fetch_if.sv | 41 ++++
 rtl/inst_fetch_fifo.sv | 87 ++++++++
 rtl/inst_fetch.sv | 106 ++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared core definitions for the instruction fetch unit: datapath width,
// fetch FSM states and the canonical NOP encoding.
package inst_fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-unit bus bundle: PC-unit address handshake, instruction memory
// request/response channel and decode-side instruction handshake.
interface inst_fetch_if;
  import inst_fetch_pkg::*;

  // PC unit -> fetch
  logic            valid_i;
  logic [XLEN-1:0] instAddr_i;
  logic            ready_o;
  logic            flush_i;

  // fetch <-> instruction memory
  logic            mem_req_o;
  logic [XLEN-1:0] mem_addr_o;
  logic            mem_gnt_i;
  logic            mem_rvalid_i;
  logic [XLEN-1:0] mem_rdata_i;

  // fetch -> decode
  logic            inst_valid_o;
  logic [XLEN-1:0] inst_o;
  logic [XLEN-1:0] instAddr_o;
  logic            inst_ready_i;

  modport slave (
    input  valid_i, instAddr_i, flush_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  inst_ready_i,
    output ready_o, mem_req_o, mem_addr_o,
    output inst_valid_o, inst_o, instAddr_o
  );

  modport master (
    output valid_i, instAddr_i, flush_i,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output inst_ready_i,
    input  ready_o, mem_req_o, mem_addr_o,
    input  inst_valid_o, inst_o, instAddr_o
  );

endinterface

// File: rtl/inst_fetch_fifo.sv
// Fetch entry storage: slots are allocated at issue, filled in order by
// memory responses and freed from the head by decode.
module fetch_fifo
  import inst_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_flush,
  input  logic                     i_alloc,
  input  logic [XLEN-1:0]          i_alloc_addr,
  input  logic                     i_fill,
  input  logic [XLEN-1:0]          i_fill_data,
  input  logic                     i_free,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_head_filled,
  output logic [XLEN-1:0]          o_head_addr,
  output logic [XLEN-1:0]          o_head_data
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [XLEN-1:0]  r_addr [DEPTH];
  logic [XLEN-1:0]  r_data [DEPTH];
  logic [DEPTH-1:0] r_filled;
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_fptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic [DEPTH-1:0] w_filled_nxt;

  // Free, alloc and fill never target the same unfilled/filled slot, so the
  // order of these updates only matters for the free/alloc overlap (both clear).
  always_comb begin
    w_filled_nxt = r_filled;
    if (i_free) begin
      w_filled_nxt[r_rptr] = 1'b0;
    end
    if (i_alloc) begin
      w_filled_nxt[r_wptr] = 1'b0;
    end
    if (i_fill) begin
      w_filled_nxt[r_fptr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
      r_filled <= '0;
      r_wptr   <= '0;
      r_fptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_filled <= '0;
      r_wptr   <= '0;
      r_fptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
    end else begin
      if (i_alloc) begin
        r_addr[r_wptr] <= i_alloc_addr;
        r_wptr         <= r_wptr + AW'(1);
      end
      if (i_fill) begin
        r_data[r_fptr] <= i_fill_data;
        r_fptr         <= r_fptr + AW'(1);
      end
      if (i_free) begin
        r_rptr <= r_rptr + AW'(1);
      end
      r_filled <= w_filled_nxt;
      r_count  <= r_count + (AW+1)'(i_alloc) - (AW+1)'(i_free);
    end
  end

  assign o_count       = r_count;
  assign o_head_filled = r_filled[r_rptr] && (r_count != '0);
  assign o_head_addr   = r_addr[r_rptr];
  assign o_head_data   = r_data[r_rptr];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: credit-based issue to instruction memory, in-order
// response capture and flush handling that drains abandoned responses.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  inst_fetch_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;
  logic [AW:0]     r_outstanding;
  logic [AW:0]     r_drain_cnt;
  logic [AW:0]     w_drain_nxt;
  logic [AW:0]     w_count;
  logic            w_head_filled;
  logic [XLEN-1:0] w_head_addr;
  logic [XLEN-1:0] w_head_data;
  logic            w_run;
  logic            w_inst_valid;
  logic            w_free;
  logic            w_credit_ok;
  logic            w_req;
  logic            w_ready;
  logic            w_rsp;
  logic            w_fill;

  assign w_run        = (r_state == RUN);
  assign w_inst_valid = w_run && w_head_filled;
  assign w_free       = w_inst_valid && bus.inst_ready_i && !bus.flush_i;
  assign w_credit_ok  = (w_count < (AW+1)'(DEPTH)) ||
                        (w_head_filled && bus.inst_ready_i);
  // Reset gating keeps the request low while reset_n is held, even though
  // the registered state already reads RUN with free credit.
  assign w_req        = reset_n && bus.valid_i && w_credit_ok && w_run &&
                        !bus.flush_i;
  assign w_ready      = w_req && bus.mem_gnt_i;
  assign w_rsp        = bus.mem_rvalid_i && (r_outstanding != '0);
  assign w_fill       = w_rsp && w_run && !bus.flush_i;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_flush       (bus.flush_i),
    .i_alloc       (w_ready),
    .i_alloc_addr  (bus.instAddr_i),
    .i_fill        (w_fill),
    .i_fill_data   (bus.mem_rdata_i),
    .i_free        (w_free),
    .o_count       (w_count),
    .o_head_filled (w_head_filled),
    .o_head_addr   (w_head_addr),
    .o_head_data   (w_head_data)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_drain_nxt = r_drain_cnt;
    if (bus.flush_i) begin
      w_drain_nxt = r_outstanding - (AW+1)'(w_rsp);
      w_state_nxt = (w_drain_nxt != '0) ? DRAIN : RUN;
    end else if ((r_state == DRAIN) && w_rsp) begin
      w_drain_nxt = r_drain_cnt - (AW+1)'(1);
      if (w_drain_nxt == '0) begin
        w_state_nxt = RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= RUN;
      r_drain_cnt   <= '0;
      r_outstanding <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_drain_cnt   <= w_drain_nxt;
      r_outstanding <= r_outstanding + (AW+1)'(w_ready) - (AW+1)'(w_rsp);
    end
  end

  assign bus.ready_o      = w_ready;
  assign bus.mem_req_o    = w_req;
  assign bus.mem_addr_o   = bus.instAddr_i;
  assign bus.inst_valid_o = w_inst_valid;
  assign bus.inst_o       = w_head_data;
  assign bus.instAddr_o   = w_head_addr;

  a_rsp_has_outstanding : assert property (
    @(posedge clk) disable iff (!reset_n)
    bus.mem_rvalid_i |-> (r_outstanding != '0)
  );

  a_outstanding_bound : assert property (
    @(posedge clk) disable iff (!reset_n)
    r_outstanding <= (AW+1)'(DEPTH)
  );

endmodule
